adc_model_mc: RTL

- Parametrised multi-channel behavioural ADC model for SoC-level simulation of the sensor subsystem; successor to the single-channel dummy ADC.
- Accepts a trigger pulse, latches a channel, and holds busy for a fixed conversion latency.
- Then delivers a registered, deterministic pseudo-random result with a done pulse and a packed status word.
- Supports single-shot and continuous round-robin scan modes, with overrun detection.

---
 rtl/adc_model_mc.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/adc_model_mc.sv
// Purpose : multi-channel behavioural ADC; trigger starts a conversion, result is a deterministic pseudo-random or full-scale code.
// Latency : trigger sampled at edge k -> done/measurement after edge k+CONV_CYCLES; continuous mode repeats every CONV_CYCLES.
// Backpres: none; triggers arriving while busy are dropped and flagged as sticky overrun.
//
// Ports:
//   clk, reset            clock; asynchronous active-high reset
//   trigger, ch_sel       start request and channel (out-of-range channel wraps to 0)
//   cont_en               round-robin continuous scan enable
//   status_clr            clears sticky valid/overrun (a coincident set wins)
//   analog_in[NUM_CH]     per-channel stand-in: 1 = full-scale, 0 = noise
//   busy, done            conversion in progress; one-cycle result pulse
//   measurement, meas_ch  last result (zero-extended) and its channel
//   status                {count[15:8], meas_ch[7:4], 0, overrun, valid, busy}
module adc_model_mc #(
    parameter int          DATA_WIDTH  = 32,
    parameter int          RES_BITS    = 12,
    parameter int          NUM_CH      = 4,
    parameter int          CONV_CYCLES = 8,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1,
    localparam int         CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  trigger,
    input  logic [CH_W-1:0]       ch_sel,
    input  logic                  cont_en,
    input  logic                  status_clr,
    input  logic [NUM_CH-1:0]     analog_in,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] measurement,
    output logic [CH_W-1:0]       meas_ch,
    output logic [DATA_WIDTH-1:0] status
);

    localparam int               CNT_W    = (CONV_CYCLES > 1) ? $clog2(CONV_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(CONV_CYCLES - 1);
    localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(NUM_CH - 1);

    typedef enum logic {IDLE, CONV} state_t;

    state_t                state;
    state_t                state_nxt;
    logic [CNT_W-1:0]      cnt;
    logic [CH_W-1:0]       cur_ch;
    logic [15:0]           lfsr;
    logic [15:0]           lfsr_nxt;
    logic [15:0]           mixed;
    logic [RES_BITS-1:0]   result;
    logic [CH_W-1:0]       ch_start;
    logic [CH_W-1:0]       ch_inc;
    logic                  complete;
    logic                  valid;
    logic                  overrun;
    logic [7:0]            conv_cnt;
    logic                  stat_busy;

    assign complete = (state == CONV) && (cnt == '0);

    // Right-shifting Galois LFSR, tap mask 16'hB400.
    assign lfsr_nxt = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);

    // Result uses the LFSR value present before this edge's advance.
    assign mixed  = lfsr ^ (16'(cur_ch) * 16'h1111);
    assign result = analog_in[cur_ch] ? {RES_BITS{1'b1}} : mixed[RES_BITS-1:0];

    assign ch_start = ({1'b0, ch_sel} >= (CH_W + 1)'(NUM_CH)) ? '0 : ch_sel;
    assign ch_inc   = (cur_ch == CH_LAST) ? '0 : cur_ch + 1'b1;

    // FSM: state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM: next state
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (trigger) state_nxt = CONV;
            CONV:    if (complete && !cont_en) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        busy = (state == CONV);
    end

    // Datapath, result and status registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lfsr        <= LFSR_SEED;
            cnt         <= '0;
            cur_ch      <= '0;
            done        <= 1'b0;
            measurement <= '0;
            meas_ch     <= '0;
            valid       <= 1'b0;
            overrun     <= 1'b0;
            conv_cnt    <= 8'd0;
            stat_busy   <= 1'b0;
        end else begin
            lfsr      <= lfsr_nxt;
            done      <= complete;
            // Status busy bit stays high through the cycle the result is presented.
            stat_busy <= (state_nxt == CONV) || complete;

            if (state == IDLE) begin
                if (trigger) begin
                    cur_ch <= ch_start;
                    cnt    <= CNT_LOAD;
                end
            end else if (cnt != '0) begin
                cnt <= cnt - 1'b1;
            end else begin
                measurement <= DATA_WIDTH'(result);
                meas_ch     <= cur_ch;
                conv_cnt    <= conv_cnt + 8'd1;
                if (cont_en) begin
                    cur_ch <= ch_inc;
                    cnt    <= CNT_LOAD;
                end
            end

            // Sticky flags: a set event in the same cycle beats status_clr.
            if (complete) begin
                valid <= 1'b1;
            end else if (status_clr) begin
                valid <= 1'b0;
            end

            if (trigger && (state == CONV)) begin
                overrun <= 1'b1;
            end else if (status_clr) begin
                overrun <= 1'b0;
            end
        end
    end

    assign status = DATA_WIDTH'({conv_cnt, 4'(meas_ch), 1'b0, overrun, valid, stat_busy});

endmodule
